alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Byte-serial sequencer around an external 8-bit ALU: one byte per cycle, carry chained.
// Optional zero-flag output enabled by defining ALU_SEQ_CTRL_ZERO_FLAG_EN.
module alu_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic [1:0]          req_sel,
  input  logic                req_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_data,
  output logic                rsp_cout,
`ifdef ALU_SEQ_CTRL_ZERO_FLAG_EN
  output logic                rsp_zero,
`endif
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_sel,
  output logic                alu_cin,
  input  logic [7:0]          alu_out,
  input  logic                alu_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q, b_q, res_q, res_d;
  logic [1:0]      sel_q;
  logic            carry_q;
  logic            ready_q, valid_q;
`ifdef ALU_SEQ_CTRL_ZERO_FLAG_EN
  logic            zero_q;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    res_d = res_q;
    if (state_q == RUN) res_d[8*k_q +: 8] = alu_out;
  end

  // The carry register is preloaded with req_cin at accept, so byte 0 sees the
  // request carry and later bytes see the previous byte's carry-out.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = a_q[8*k_q +: 8];
      alu_b   = b_q[8*k_q +: 8];
      alu_sel = sel_q;
      alu_cin = carry_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result and operand registers are reset too; the response must read zero straight after reset.
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef ALU_SEQ_CTRL_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          a_q     <= req_a;
          b_q     <= req_b;
          sel_q   <= req_sel;
          carry_q <= req_cin;
          k_q     <= '0;
          ready_q <= 1'b0;
          state_q <= RUN;
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= alu_cout;
          if (k_q == KLAST) begin
            valid_q <= 1'b1;
            state_q <= DONE;
`ifdef ALU_SEQ_CTRL_ZERO_FLAG_EN
            zero_q  <= (res_d == '0);
`endif
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: if (rsp_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          k_q     <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = res_q;
  assign rsp_cout  = carry_q;
`ifdef ALU_SEQ_CTRL_ZERO_FLAG_EN
  assign rsp_zero  = zero_q;
`endif

endmodule
